// File: rtl/counter_mod.sv
// -----------------------------------------------------------------------------
// counter_mod
//   Parametrised modulo-DEPTH up/down counter with synchronous clear,
//   clamped parallel load, wrap or saturate behaviour at the range ends, a
//   combinational terminal-count output for cascading stages and a registered
//   one-cycle wrap pulse.
//
// Parameters
//   DEPTH   modulus, count range 0..DEPTH-1 (DEPTH >= 2)
//   MODE    0 = wrap at range ends, 1 = saturate at range ends
//
// Ports
//   clk_i     in   1       clock, rising edge
//   rstn_i    in   1       asynchronous active-low reset
//   clr_i     in   1       synchronous clear to 0 (highest priority)
//   load_i    in   1       synchronous load of data_i (clamped to DEPTH-1)
//   data_i    in   AWIDTH  load value
//   ena_i     in   1       count enable, one step per enabled cycle
//   dir_i     in   1       0 = up, 1 = down
//   count_o   out  AWIDTH  current count, registered
//   tc_o      out  1       terminal count / carry-out, combinational
//   wrap_o    out  1       one-cycle registered pulse after a wrap step
// -----------------------------------------------------------------------------
module counter_mod #(
    parameter int DEPTH = 8,
    parameter int MODE  = 0
) (
    input  logic                                       clk_i,
    input  logic                                       rstn_i,
    input  logic                                       clr_i,
    input  logic                                       load_i,
    input  logic [((DEPTH <= 2) ? 1 : $clog2(DEPTH))-1:0] data_i,
    input  logic                                       ena_i,
    input  logic                                       dir_i,
    output logic [((DEPTH <= 2) ? 1 : $clog2(DEPTH))-1:0] count_o,
    output logic                                       tc_o,
    output logic                                       wrap_o
);

    localparam int AWIDTH = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

    // Range limit held one bit wider so DEPTH = 2^AWIDTH cannot overflow.
    localparam logic [AWIDTH:0]   MAX_EXT = (AWIDTH + 1)'(DEPTH - 1);
    localparam logic [AWIDTH-1:0] MAX_CNT = AWIDTH'(DEPTH - 1);

    logic [AWIDTH-1:0] count_q, count_d;
    logic              wrap_q, wrap_d;
    logic              atTop, atBottom;

    // Range-end detection on the widened count.
    always_comb begin
        atTop    = ({1'b0, count_q} == MAX_EXT);
        atBottom = (count_q == '0);
    end

    // Carry/borrow for the next stage; deliberately not masked by clr/load.
    always_comb begin
        tc_o = ena_i & ((~dir_i & atTop) | (dir_i & atBottom));
    end

    // Next-state: clear beats load beats enable. A wrap step is the only
    // thing that raises the pulse, so it drops back to 0 on any other cycle.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            if ({1'b0, data_i} > MAX_EXT) begin
                count_d = MAX_CNT;
            end else begin
                count_d = data_i;
            end
        end else if (ena_i) begin
            if (!dir_i) begin
                if (!atTop) begin
                    count_d = count_q + AWIDTH'(1);
                end else if (MODE == 0) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (!atBottom) begin
                    count_d = count_q - AWIDTH'(1);
                end else if (MODE == 0) begin
                    count_d = MAX_CNT;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_counter_mod.sv
// -----------------------------------------------------------------------------
// tb_counter_mod
//   Bench for counter_mod: a DEPTH=5 wrapping instance, a DEPTH=5 saturating
//   instance, and two DEPTH=8 instances cascaded through tc_o. Vector tables
//   drive the DEPTH=5 instances; expected count/wrap values go into a
//   scoreboard queue when stimulus is applied and are popped after the edge.
// -----------------------------------------------------------------------------
module tb_counter_mod;

    typedef struct {
        int    sel;
        bit    clr;
        bit    load;
        int    data;
        bit    ena;
        bit    dir;
        bit    expTc;
        int    expCnt;
        bit    expWrap;
        string tag;
    } vecT;

    typedef struct {
        int    sel;
        int    cnt;
        bit    wrap;
        string tag;
    } expT;

    int nChecks = 0;
    int nFail   = 0;

    vecT vecs[$];
    expT sb[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=5 instances
    logic       rst5n;
    logic       clrW, loadW, enaW, dirW, tcW, wrapW;
    logic [2:0] dataW, cntW;
    logic       clrS, loadS, enaS, dirS, tcS, wrapS;
    logic [2:0] dataS, cntS;

    // DEPTH=8 cascade
    logic       rst8n, enaA, dir8, tcA, wrapA, tcB, wrapB;
    logic       zeroBit;
    logic [2:0] zeroData, cntA, cntB;

    counter_mod #(.DEPTH(5), .MODE(0)) uWrap (
        .clk_i(clk), .rstn_i(rst5n), .clr_i(clrW), .load_i(loadW),
        .data_i(dataW), .ena_i(enaW), .dir_i(dirW),
        .count_o(cntW), .tc_o(tcW), .wrap_o(wrapW));

    counter_mod #(.DEPTH(5), .MODE(1)) uSat (
        .clk_i(clk), .rstn_i(rst5n), .clr_i(clrS), .load_i(loadS),
        .data_i(dataS), .ena_i(enaS), .dir_i(dirS),
        .count_o(cntS), .tc_o(tcS), .wrap_o(wrapS));

    counter_mod #(.DEPTH(8), .MODE(0)) uStageA (
        .clk_i(clk), .rstn_i(rst8n), .clr_i(zeroBit), .load_i(zeroBit),
        .data_i(zeroData), .ena_i(enaA), .dir_i(dir8),
        .count_o(cntA), .tc_o(tcA), .wrap_o(wrapA));

    counter_mod #(.DEPTH(8), .MODE(0)) uStageB (
        .clk_i(clk), .rstn_i(rst8n), .clr_i(zeroBit), .load_i(zeroBit),
        .data_i(zeroData), .ena_i(tcA), .dir_i(dir8),
        .count_o(cntB), .tc_o(tcB), .wrap_o(wrapB));

    // Single comparison point: every check steps nChecks, failures nFail.
    task automatic compareValue(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic addVec(input int sel, input bit clr, input bit load, input int data,
                          input bit ena, input bit dir, input bit expTc,
                          input int expCnt, input bit expWrap, input string tag);
        vecT v;
        v.sel = sel; v.clr = clr; v.load = load; v.data = data; v.ena = ena;
        v.dir = dir; v.expTc = expTc; v.expCnt = expCnt; v.expWrap = expWrap;
        v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic pushExp(input int sel, input int cnt, input bit wrap, input string tag);
        expT e;
        e.sel = sel; e.cnt = cnt; e.wrap = wrap; e.tag = tag;
        sb.push_back(e);
    endtask

    // Drive one vector on the falling edge, check the combinational tc_o,
    // and queue the post-edge expectation.
    task automatic applyStimulus(input vecT v);
        @(negedge clk);
        clrW = 1'b0; loadW = 1'b0; enaW = 1'b0; dirW = 1'b0; dataW = 3'd0;
        clrS = 1'b0; loadS = 1'b0; enaS = 1'b0; dirS = 1'b0; dataS = 3'd0;
        if (v.sel == 0) begin
            clrW = v.clr; loadW = v.load; enaW = v.ena; dirW = v.dir; dataW = 3'(v.data);
        end else begin
            clrS = v.clr; loadS = v.load; enaS = v.ena; dirS = v.dir; dataS = 3'(v.data);
        end
        #1;
        compareValue({v.tag, " tc"}, (v.sel == 0) ? int'(tcW) : int'(tcS), int'(v.expTc));
        pushExp(v.sel, v.expCnt, v.expWrap, v.tag);
    endtask

    // Sample #1 after the rising edge and compare against the scoreboard.
    task automatic checkOutput();
        expT e;
        int  actCnt;
        int  actWrap;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            compareValue("scoreboard empty", 0, 1);
        end else begin
            e = sb.pop_front();
            case (e.sel)
                0:       begin actCnt = int'(cntW); actWrap = int'(wrapW); end
                1:       begin actCnt = int'(cntS); actWrap = int'(wrapS); end
                default: begin actCnt = int'({cntB, cntA}); actWrap = int'(wrapA); end
            endcase
            compareValue({e.tag, " count"}, actCnt, e.cnt);
            compareValue({e.tag, " wrap"}, actWrap, int'(e.wrap));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // sel clr load data ena dir | tc cnt wrap
        for (int i = 0; i < 12; i++) begin
            addVec(0, 0, 0, 0, 1, 0, ((i % 5) == 4), (i + 1) % 5, ((i % 5) == 4), "wrapUp");
        end
        addVec(0, 1, 0, 0, 1, 0, 0, 0, 0, "clrBeatsEna");
        addVec(0, 0, 0, 0, 1, 1, 1, 4, 1, "wrapDown0");
        addVec(0, 0, 0, 0, 1, 1, 0, 3, 0, "wrapDown1");
        addVec(0, 0, 0, 0, 1, 1, 0, 2, 0, "wrapDown2");
        addVec(0, 0, 0, 0, 1, 1, 0, 1, 0, "wrapDown3");
        addVec(0, 0, 0, 0, 1, 1, 0, 0, 0, "wrapDown4");
        addVec(0, 0, 0, 0, 1, 1, 1, 4, 1, "wrapDown5");
        addVec(0, 0, 0, 0, 1, 1, 0, 3, 0, "wrapDown6");
        addVec(0, 0, 0, 0, 1, 0, 0, 4, 0, "dirUp");
        addVec(0, 0, 0, 0, 1, 0, 1, 0, 1, "dirUpWrap");
        addVec(0, 0, 0, 0, 1, 1, 1, 4, 1, "dirDownWrapB2B");
        addVec(0, 0, 0, 0, 1, 1, 0, 3, 0, "dirDown");
        addVec(0, 1, 1, 3, 1, 0, 0, 0, 0, "clrBeatsLoad");
        addVec(0, 1, 0, 0, 1, 1, 1, 0, 0, "tcNotMaskedClr");
        addVec(0, 0, 1, 3, 0, 0, 0, 3, 0, "load3");
        addVec(0, 0, 1, 7, 0, 0, 0, 4, 0, "load7Clamp");
        addVec(0, 0, 1, 2, 1, 0, 1, 2, 0, "loadBeatsWrap");
        addVec(0, 0, 0, 0, 0, 0, 0, 2, 0, "hold");
        addVec(0, 0, 1, 5, 0, 0, 0, 4, 0, "load5Clamp");
        addVec(0, 0, 0, 0, 1, 0, 1, 0, 1, "wrapAgain");
        addVec(0, 0, 1, 4, 0, 0, 0, 4, 0, "pulseOneCycle");
        for (int i = 0; i < 8; i++) begin
            addVec(1, 0, 0, 0, 1, 0, (i >= 4), (i < 4) ? i + 1 : 4, 0, "satUp");
        end
        for (int i = 0; i < 6; i++) begin
            addVec(1, 0, 0, 0, 1, 1, (i >= 4), (i < 4) ? 3 - i : 0, 0, "satDown");
        end
        addVec(1, 0, 1, 6, 0, 0, 0, 4, 0, "satLoadClamp");

        rst5n = 1'b0; rst8n = 1'b0;
        clrW = 0; loadW = 0; enaW = 0; dirW = 0; dataW = 0;
        clrS = 0; loadS = 0; enaS = 0; dirS = 0; dataS = 0;
        enaA = 0; dir8 = 0; zeroBit = 0; zeroData = 3'd0;

        // Reset values, and tc_o still decoding during reset.
        #12;
        compareValue("resetCntW", int'(cntW), 0);
        compareValue("resetWrapW", int'(wrapW), 0);
        compareValue("resetCntS", int'(cntS), 0);
        compareValue("resetCascade", int'({cntB, cntA}), 0);
        enaW = 1; dirW = 1;
        #1;
        compareValue("resetTcDown", int'(tcW), 1);
        enaW = 0; dirW = 0;
        @(negedge clk);
        rst5n = 1'b1; rst8n = 1'b1;

        $display("[TB] table vectors: %0d", vecs.size());
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // Wrap pulse cleared asynchronously by reset between edges.
        @(negedge clk);
        clrS = 0; loadS = 0; enaS = 0;
        loadW = 1; dataW = 3'd0; enaW = 0;
        @(negedge clk);
        loadW = 0; enaW = 1; dirW = 1;
        @(posedge clk);
        #1;
        compareValue("preResetCntW", int'(cntW), 4);
        compareValue("preResetWrapW", int'(wrapW), 1);
        enaW = 0;
        #2;
        rst5n = 1'b0;
        #1;
        compareValue("asyncRstCntW", int'(cntW), 0);
        compareValue("asyncRstWrapW", int'(wrapW), 0);

        // Cascade: {B,A} tracks elapsed enabled cycles mod 64.
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            enaA = 1'b1;
            #1;
            compareValue("cascadeTcA", int'(tcA), int'(((k - 1) % 8) == 7));
            pushExp(2, k % 64, ((k - 1) % 8) == 7, "cascade");
            checkOutput();
        end

        // Asynchronous reset at count 6, then first step from 0.
        @(negedge clk);
        enaA = 1'b0;
        #1;
        compareValue("preResetCntA", int'(cntA), 6);
        #1;
        rst8n = 1'b0;
        #1;
        compareValue("asyncRstCntA", int'(cntA), 0);
        compareValue("asyncRstWrapA", int'(wrapA), 0);
        enaA = 1'b1;
        #1;
        rst8n = 1'b1;
        @(posedge clk);
        #1;
        compareValue("firstStepAfterRst", int'(cntA), 1);

        compareValue("scoreboardDrained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
